// File: rtl/vga_sync_if.sv
// Raster timing bundle carried from vga_sync to pixel_gen and the connector pins.
// Latency: none, wires only.
// Backpressure: none; the display side always consumes one pixel per clk_d cycle.
//
// Signals:
//   pixel_x, pixel_y : current column / row (10-bit)
//   video_on         : pixel is inside the visible area
//   hsync, vsync     : sync pulses at the polarity chosen by the generator
//   line_start       : one-cycle pulse at pixel_x == 0
//   frame_start      : one-cycle pulse at pixel_x == 0 and pixel_y == 0
//   frame_count      : frames completed since reset, wraps at 2^16
// Modports: master = timing generator, slave = consumer.
interface vga_sync_if;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        video_on;
   logic        hsync;
   logic        vsync;
   logic        line_start;
   logic        frame_start;
   logic [15:0] frame_count;

   modport master (
      output pixel_x, pixel_y, video_on, hsync, vsync,
             line_start, frame_start, frame_count
   );

   modport slave (
      input  pixel_x, pixel_y, video_on, hsync, vsync,
             line_start, frame_start, frame_count
   );
endinterface

// File: rtl/vga_sync.sv
// Raster timing generator: cascaded h/v counters decoded into coordinates,
// blanking, sync pulses, line/frame strobes and a frame counter.
// Latency: 0 cycles from the counters (1 cycle when VGA_SYNC_OUT_REG_EN is defined).
// Backpressure: none; free-running one pixel per clk_d cycle, no enable.
//
// Ports:
//   clk_d : pixel clock, every flop on its rising edge
//   rst   : synchronous active-high reset, restarts the raster at (0,0)
//   vga   : vga_sync_if.master, all timing outputs
//
// Optional build macro VGA_SYNC_OUT_REG_EN: adds one register stage on every
// output so the pins are glitch-free; all outputs then lag the counters by
// exactly one cycle and stay mutually aligned.
module vga_sync #(
   parameter int   H_DISPLAY   = 640,
   parameter int   H_FRONT     = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BACK      = 48,
   parameter int   V_DISPLAY   = 480,
   parameter int   V_FRONT     = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BACK      = 33,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic          clk_d,
   input  logic          rst,
   vga_sync_if.master    vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   // The counters are 10 bits wide, so larger rasters cannot be represented.
   if (H_TOTAL > 1024) begin : g_h_total_chk
      $error("vga_sync: H_TOTAL=%0d exceeds 1024", H_TOTAL);
   end
   if (V_TOTAL > 1024) begin : g_v_total_chk
      $error("vga_sync: V_TOTAL=%0d exceeds 1024", V_TOTAL);
   end

   localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

   // Decode thresholds are kept 11 bits wide: with a total of exactly 1024 the
   // end of a sync window can be 1024, which does not fit in the counter width.
   localparam logic [10:0] H_VIS_END  = 11'(H_DISPLAY);
   localparam logic [10:0] H_SYNC_BEG = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] H_SYNC_END = 11'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [10:0] V_VIS_END  = 11'(V_DISPLAY);
   localparam logic [10:0] V_SYNC_BEG = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0] V_SYNC_END = 11'(V_DISPLAY + V_FRONT + V_SYNC);

   // ------------------------------------------------------------------
   // Cascaded counters
   // ------------------------------------------------------------------
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic [15:0] frame_cnt;
   logic        h_last;
   logic        v_last;

   assign h_last = (h_cnt == H_MAX);
   assign v_last = (v_cnt == V_MAX);

   always_ff @(posedge clk_d) begin
      if (rst) begin
         h_cnt     <= '0;
         v_cnt     <= '0;
         frame_cnt <= '0;
      end else begin
         h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
         // v only advances on the h wrap; the frame completes when both wrap.
         if (h_last) begin
            v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            if (v_last) begin
               frame_cnt <= frame_cnt + 16'd1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Combinational decode of the counter state
   // ------------------------------------------------------------------
   logic [10:0] h_ext;
   logic [10:0] v_ext;
   logic        video_on_c;
   logic        h_in_sync;
   logic        v_in_sync;
   logic        hsync_c;
   logic        vsync_c;
   logic        line_start_c;
   logic        frame_start_c;

   assign h_ext = {1'b0, h_cnt};
   assign v_ext = {1'b0, v_cnt};

   assign video_on_c    = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
   assign h_in_sync     = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
   assign v_in_sync     = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
   assign hsync_c       = h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign vsync_c       = v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign line_start_c  = (h_cnt == 10'd0);
   assign frame_start_c = (h_cnt == 10'd0) && (v_cnt == 10'd0);

`ifdef VGA_SYNC_OUT_REG_EN
   // ------------------------------------------------------------------
   // Output register stage. Reset values equal the decode of (0,0) so the
   // pins show the same picture during reset as the unregistered build.
   // ------------------------------------------------------------------
   logic [9:0]  pixel_x_q;
   logic [9:0]  pixel_y_q;
   logic        video_on_q;
   logic        hsync_q;
   logic        vsync_q;
   logic        line_start_q;
   logic        frame_start_q;
   logic [15:0] frame_count_q;

   always_ff @(posedge clk_d) begin
      if (rst) begin
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         video_on_q    <= 1'b1;
         hsync_q       <= ~SYNC_ACTIVE;
         vsync_q       <= ~SYNC_ACTIVE;
         line_start_q  <= 1'b1;
         frame_start_q <= 1'b1;
         frame_count_q <= '0;
      end else begin
         pixel_x_q     <= h_cnt;
         pixel_y_q     <= v_cnt;
         video_on_q    <= video_on_c;
         hsync_q       <= hsync_c;
         vsync_q       <= vsync_c;
         line_start_q  <= line_start_c;
         frame_start_q <= frame_start_c;
         frame_count_q <= frame_cnt;
      end
   end

   assign vga.pixel_x     = pixel_x_q;
   assign vga.pixel_y     = pixel_y_q;
   assign vga.video_on    = video_on_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;
   assign vga.frame_count = frame_count_q;
`else
   // Direct decode: outputs track the counters with zero latency.
   assign vga.pixel_x     = h_cnt;
   assign vga.pixel_y     = v_cnt;
   assign vga.video_on    = video_on_c;
   assign vga.hsync       = hsync_c;
   assign vga.vsync       = vsync_c;
   assign vga.line_start  = line_start_c;
   assign vga.frame_start = frame_start_c;
   assign vga.frame_count = frame_cnt;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a full-size 640x480 instance for reset and line timing,
// and a reduced raster instance (15x13, positive sync) for frame timing,
// mid-frame reset and frame_count wrap within a short run.
module tb_vga_sync;

`ifdef VGA_SYNC_OUT_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   // reduced raster geometry
   localparam int BHD = 8, BHF = 2, BHS = 3, BHB = 2;
   localparam int BVD = 6, BVF = 2, BVS = 2, BVB = 3;
   localparam int BHT = BHD + BHF + BHS + BHB;   // 15
   localparam int BVT = BVD + BVF + BVS + BVB;   // 13
   localparam int BFR = BHT * BVT;               // 195

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        von;
      logic        hs;
      logic        vs;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } out_t;

   typedef struct {
      int   ct;
      out_t o;
   } vec_t;

   logic clk_d = 1'b0;
   logic rst_a;
   logic rst_b;
   int   checks = 0;
   int   failures = 0;

   always #20 clk_d = ~clk_d;

   vga_sync_if va ();
   vga_sync_if vb ();

   vga_sync dut_a (
      .clk_d (clk_d),
      .rst   (rst_a),
      .vga   (va)
   );

   vga_sync #(
      .H_DISPLAY(BHD), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
      .V_DISPLAY(BVD), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
      .SYNC_ACTIVE(1'b1)
   ) dut_b (
      .clk_d (clk_d),
      .rst   (rst_b),
      .vga   (vb)
   );

   function automatic out_t mk(input int x, input int y, input logic von, input logic hs,
                               input logic vs, input logic ls, input logic fs, input int fc);
      out_t o;
      o.x = 10'(x); o.y = 10'(y); o.von = von; o.hs = hs; o.vs = vs;
      o.ls = ls; o.fs = fs; o.fc = 16'(fc);
      return o;
   endfunction

   // Expected outputs after ct counter steps from reset, from raster arithmetic.
   function automatic out_t model(input int ct, input int hd, input int hf, input int hsw,
                                  input int hb, input int vd, input int vf, input int vsw,
                                  input int vb, input logic sa);
      out_t o;
      int c, ht, vt, h, v;
      c  = (ct < 0) ? 0 : ct;
      ht = hd + hf + hsw + hb;
      vt = vd + vf + vsw + vb;
      h  = c % ht;
      v  = (c / ht) % vt;
      o.x   = 10'(h);
      o.y   = 10'(v);
      o.von = (h < hd) && (v < vd);
      o.hs  = (h >= hd + hf && h < hd + hf + hsw) ? sa : ~sa;
      o.vs  = (v >= vd + vf && v < vd + vf + vsw) ? sa : ~sa;
      o.ls  = (h == 0);
      o.fs  = (h == 0) && (v == 0);
      o.fc  = 16'(c / (ht * vt));
      return o;
   endfunction

   function automatic out_t model_a(input int ct);
      return model(ct, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
   endfunction

   function automatic out_t model_b(input int ct);
      return model(ct, BHD, BHF, BHS, BHB, BVD, BVF, BVS, BVB, 1'b1);
   endfunction

   function automatic out_t obs_a();
      return {va.pixel_x, va.pixel_y, va.video_on, va.hsync, va.vsync,
              va.line_start, va.frame_start, va.frame_count};
   endfunction

   function automatic out_t obs_b();
      return {vb.pixel_x, vb.pixel_y, vb.video_on, vb.hsync, vb.vsync,
              vb.line_start, vb.frame_start, vb.frame_count};
   endfunction

   task automatic check(input string nm, input out_t got, input out_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got x=%0d y=%0d von=%b hs=%b vs=%b ls=%b fs=%b fc=%h, required x=%0d y=%0d von=%b hs=%b vs=%b ls=%b fs=%b fc=%h",
                  nm, got.x, got.y, got.von, got.hs, got.vs, got.ls, got.fs, got.fc,
                  exp.x, exp.y, exp.von, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
      end
   endtask

   task automatic check_int(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_d);
      @(negedge clk_d);
   endtask

   vec_t vec[13];
   out_t rst_val_a;
   out_t rst_val_b;

   initial begin
      int   ct;
      int   hs_lo_l0, hs_lo_l1, ls_cnt, vs_act, von_cnt, fs_cnt;
      out_t o;

      // full-size raster, negative sync: idle level is 1
      vec[0]  = '{0,    mk(0,   0, 1, 1, 1, 1, 1, 0)};
      vec[1]  = '{1,    mk(1,   0, 1, 1, 1, 0, 0, 0)};
      vec[2]  = '{639,  mk(639, 0, 1, 1, 1, 0, 0, 0)};
      vec[3]  = '{640,  mk(640, 0, 0, 1, 1, 0, 0, 0)};
      vec[4]  = '{655,  mk(655, 0, 0, 1, 1, 0, 0, 0)};
      vec[5]  = '{656,  mk(656, 0, 0, 0, 1, 0, 0, 0)};
      vec[6]  = '{751,  mk(751, 0, 0, 0, 1, 0, 0, 0)};
      vec[7]  = '{752,  mk(752, 0, 0, 1, 1, 0, 0, 0)};
      vec[8]  = '{799,  mk(799, 0, 0, 1, 1, 0, 0, 0)};
      vec[9]  = '{800,  mk(0,   1, 1, 1, 1, 1, 0, 0)};
      vec[10] = '{1456, mk(656, 1, 0, 0, 1, 0, 0, 0)};
      vec[11] = '{1599, mk(799, 1, 0, 1, 1, 0, 0, 0)};
      vec[12] = '{1600, mk(0,   2, 1, 1, 1, 1, 0, 0)};

      rst_val_a = mk(0, 0, 1, 1, 1, 1, 1, 0);
      rst_val_b = mk(0, 0, 1, 0, 0, 1, 1, 0);

      rst_a = 1'b1;
      rst_b = 1'b1;

      // reset held for three edges
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rst_hold_a%0d", i), obs_a(), rst_val_a);
      end
      checks++;
      if ($isunknown(obs_a()) || $isunknown(obs_b())) begin
         failures++;
         $display("FAIL xfree: got a=%h b=%h, required no X/Z bits", obs_a(), obs_b());
      end

      // line timing on the full-size raster
      rst_a = 1'b0;
      hs_lo_l0 = 0; hs_lo_l1 = 0; ls_cnt = 0;
      for (int t = 0; t <= 1600 + LAT; t++) begin
         if (t > 0) tick();
         ct = t - LAT;
         o  = obs_a();
         check($sformatf("line_a t=%0d", t), o, model_a(ct));
         for (int i = 0; i < 13; i++) begin
            if (vec[i].ct == ct) check($sformatf("vec_a ct=%0d", ct), o, vec[i].o);
         end
         if (ct >= 0 && ct < 800) begin
            if (!o.hs) hs_lo_l0++;
            if (o.ls)  ls_cnt++;
         end
         if (ct >= 800 && ct < 1600 && !o.hs) hs_lo_l1++;
      end
      check_int("hsync_low_line0", hs_lo_l0, 96);
      check_int("hsync_low_line1", hs_lo_l1, 96);
      check_int("line_start_per_line", ls_cnt, 1);

      // dut_b has been in reset all along: outputs must still hold reset values
      check("rst_held_b", obs_b(), rst_val_b);

      // frame timing on the reduced raster, then into the second frame
      rst_b = 1'b0;
      vs_act = 0; von_cnt = 0; ls_cnt = 0; fs_cnt = 0;
      for (int t = 0; t <= 326 + LAT; t++) begin
         if (t > 0) tick();
         ct = t - LAT;
         o  = obs_b();
         check($sformatf("frame_b t=%0d", t), o, model_b(ct));
         if (ct >= 0 && ct < BFR) begin
            if (o.vs)  vs_act++;
            if (o.von) von_cnt++;
            if (o.ls)  ls_cnt++;
            if (o.fs)  fs_cnt++;
         end
         if (ct == 120) check("vsync_first_b", o, mk(0, 8, 0, 0, 1, 1, 0, 0));
         if (ct == 194) check("frame_last_b", o, mk(14, 12, 0, 0, 0, 0, 0, 0));
         if (ct == 195) check("frame_wrap_b", o, mk(0, 0, 1, 0, 0, 1, 1, 1));
         if (ct == 326) check("pre_rst_b", o, mk(11, 8, 0, 1, 1, 0, 0, 1));
      end
      check_int("vsync_active_cycles", vs_act, BVS * BHT);
      check_int("video_on_cycles", von_cnt, BHD * BVD);
      check_int("line_start_per_frame", ls_cnt, BVT);
      check_int("frame_start_per_frame", fs_cnt, 1);

      // one-cycle reset while inside both sync pulses
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      check("mid_rst_b", obs_b(), rst_val_b);

      // preload the frame counter to its maximum and run to the frame end
      force dut_b.frame_cnt = 16'hFFFF;
      tick();
      release dut_b.frame_cnt;
      for (int t = 2; t <= BFR + 1 + LAT; t++) begin
         tick();
         ct = t - LAT;
         o  = obs_b();
         if (ct == 194) check("fc_max_b", o, mk(14, 12, 0, 0, 0, 0, 0, 16'hFFFF));
         if (ct == 195) check("fc_wrap_b", o, mk(0, 0, 1, 0, 0, 1, 1, 0));
         if (ct == 196) check("fc_after_wrap_b", o, mk(1, 0, 1, 0, 0, 0, 0, 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
